axis_read_sched: RTL and testbench

Descriptor scheduler that sits directly upstream of the stream read engine and drives its configuration bus.
- Accepts read descriptors (start address, stream length) on a valid/ready port and queues them in a small FIFO.
- Issues the three-word config sequence per descriptor: ID, then address, then length.
- Snoops the engine's output stream handshake and holds off the next sequence until every beat of the current transfer has been consumed. The config bus has no back-pressure, so this is the only safe issue point.

---
 rtl/axis_read_sched_if.sv | 28 ++
 rtl/axis_read_sched.sv | 189 ++++++++++++++++++
 tb/tb_axis_read_sched.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_read_sched_if.sv
// Bus bundle for the descriptor scheduler: descriptor input, engine config
// output and the snooped engine output-stream handshake.
interface axis_read_sched_if #(
    parameter int CONFIG_AWIDTH = 5,
    parameter int CONFIG_DWIDTH = 32
);
    logic [CONFIG_DWIDTH-1:0] desc_addr;
    logic [CONFIG_DWIDTH-1:0] desc_length;
    logic                     desc_valid;
    logic                     desc_ready;
    logic [CONFIG_AWIDTH-1:0] cfg_addr;
    logic [CONFIG_DWIDTH-1:0] cfg_data;
    logic                     cfg_valid;
    logic                     mon_valid;
    logic                     mon_ready;

    // Scheduler side
    modport master (
        input  desc_addr, desc_length, desc_valid, mon_valid, mon_ready,
        output desc_ready, cfg_addr, cfg_data, cfg_valid
    );

    // Descriptor source / engine side
    modport slave (
        output desc_addr, desc_length, desc_valid, mon_valid, mon_ready,
        input  desc_ready, cfg_addr, cfg_data, cfg_valid
    );
endinterface

// File: rtl/axis_read_sched.sv
// Read descriptor scheduler: queues descriptors and issues ID/ADDR/LEN config
// words to the stream read engine once the previous transfer has drained.
// Optional status outputs (done, done_cnt) under AXIS_READ_SCHED_STATUS_EN.
module axis_read_sched #(
    parameter int CONFIG_ID     = 1,
    parameter int CONFIG_ADDR   = 23,
    parameter int CONFIG_DATA   = 24,
    parameter int CONFIG_AWIDTH = 5,
    parameter int CONFIG_DWIDTH = 32,
    parameter int FIFO_AWIDTH   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    axis_read_sched_if.master    bus,
    output logic                 busy
`ifdef AXIS_READ_SCHED_STATUS_EN
    ,
    output logic                 done,
    output logic [15:0]          done_cnt
`endif
);
    localparam int DEPTH = 1 << FIFO_AWIDTH;

    typedef struct packed {
        logic [CONFIG_DWIDTH-1:0] addr;
        logic [CONFIG_DWIDTH-1:0] len;
    } desc_t;

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_ID   = 5'b00010,
        S_ADDR = 5'b00100,
        S_LEN  = 5'b01000,
        S_RUN  = 5'b10000
    } state_t;

    state_t                   state_q, state_d;
    desc_t                    mem_q [DEPTH];
    logic [FIFO_AWIDTH-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AWIDTH:0]     count_q, count_d;
    logic [CONFIG_DWIDTH-1:0] r_addr_q, r_addr_d, r_len_q, r_len_d;
    logic [CONFIG_DWIDTH-1:0] cnt_q, cnt_d;
    logic [CONFIG_AWIDTH-1:0] cfg_addr_q, cfg_addr_d;
    logic [CONFIG_DWIDTH-1:0] cfg_data_q, cfg_data_d;
    logic                     cfg_valid_q, cfg_valid_d;
    logic                     push, pop, empty, full, beat;
    desc_t                    head;
`ifdef AXIS_READ_SCHED_STATUS_EN
    logic                     done_q, done_d;
    logic [15:0]              done_cnt_q, done_cnt_d;
`endif

    assign empty = (count_q == '0);
    assign full  = (count_q == (FIFO_AWIDTH+1)'(DEPTH));
    assign push  = bus.desc_valid & ~full;
    assign beat  = bus.mon_valid & bus.mon_ready;
    assign head  = mem_q[rd_ptr_q];

    assign bus.desc_ready = ~full;
    assign bus.cfg_addr   = cfg_addr_q;
    assign bus.cfg_data   = cfg_data_q;
    assign bus.cfg_valid  = cfg_valid_q;
    assign busy           = (state_q != S_IDLE) | ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + FIFO_AWIDTH'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + FIFO_AWIDTH'(1);
        if (push && !pop)      count_d = count_q + (FIFO_AWIDTH+1)'(1);
        else if (!push && pop) count_d = count_q - (FIFO_AWIDTH+1)'(1);
    end

    // Config words are loaded for the state being entered, so each word is
    // visible on the bus for exactly the cycle the FSM sits in that state.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        r_addr_d    = r_addr_q;
        r_len_d     = r_len_q;
        cnt_d       = cnt_q;
        cfg_valid_d = 1'b0;
        cfg_addr_d  = cfg_addr_q;
        cfg_data_d  = cfg_data_q;
`ifdef AXIS_READ_SCHED_STATUS_EN
        done_d      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    r_addr_d = head.addr;
                    r_len_d  = head.len;
                    if (head.len == '0) begin
`ifdef AXIS_READ_SCHED_STATUS_EN
                        done_d = 1'b1;
`endif
                    end else begin
                        state_d     = S_ID;
                        cfg_valid_d = 1'b1;
                        cfg_addr_d  = CONFIG_AWIDTH'(CONFIG_ADDR);
                        cfg_data_d  = CONFIG_DWIDTH'(CONFIG_ID);
                    end
                end
            end
            S_ID: begin
                state_d     = S_ADDR;
                cfg_valid_d = 1'b1;
                cfg_addr_d  = CONFIG_AWIDTH'(CONFIG_DATA);
                cfg_data_d  = r_addr_q;
            end
            S_ADDR: begin
                state_d     = S_LEN;
                cfg_valid_d = 1'b1;
                cfg_addr_d  = CONFIG_AWIDTH'(CONFIG_DATA);
                cfg_data_d  = r_len_q;
            end
            S_LEN: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
            S_RUN: begin
                // Compare against r_len-1 rather than cnt+1 so a full-range
                // length never needs a wider counter.
                if (beat) begin
                    cnt_d = cnt_q + CONFIG_DWIDTH'(1);
                    if (cnt_q == r_len_q - CONFIG_DWIDTH'(1)) begin
                        state_d = S_IDLE;
`ifdef AXIS_READ_SCHED_STATUS_EN
                        done_d  = 1'b1;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{addr: bus.desc_addr, len: bus.desc_length};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            r_addr_q    <= '0;
            r_len_q     <= '0;
            cnt_q       <= '0;
            cfg_valid_q <= 1'b0;
            cfg_addr_q  <= '0;
            cfg_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            r_addr_q    <= r_addr_d;
            r_len_q     <= r_len_d;
            cnt_q       <= cnt_d;
            cfg_valid_q <= cfg_valid_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_data_q  <= cfg_data_d;
        end
    end

`ifdef AXIS_READ_SCHED_STATUS_EN
    always_comb begin
        done_cnt_d = done_cnt_q;
        if (done_d) done_cnt_d = done_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q     <= 1'b0;
            done_cnt_q <= '0;
        end else begin
            done_q     <= done_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    assign done     = done_q;
    assign done_cnt = done_cnt_q;
`endif
endmodule

// File: tb/tb_axis_read_sched.sv
// Bench for axis_read_sched: transaction-level model (descriptor queue, pending
// config words, beats-remaining countdown) compared every cycle, plus literals.
module tb_axis_read_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
`ifdef AXIS_READ_SCHED_STATUS_EN
    logic        done;
    logic [15:0] done_cnt;
`endif

    axis_read_sched_if #(.CONFIG_AWIDTH(5), .CONFIG_DWIDTH(32)) bus ();

    axis_read_sched dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy)
`ifdef AXIS_READ_SCHED_STATUS_EN
        ,
        .done     (done),
        .done_cnt (done_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- model ----------------
    typedef struct { logic [31:0] a; logic [31:0] l; } d_t;
    typedef struct { logic [4:0] a; logic [31:0] d; } w_t;
    d_t mq[$];
    w_t pend[$];
    bit              e_cv = 0;
    logic [4:0]      e_ca = '0;
    logic [31:0]     e_cd = '0;
    longint unsigned rem  = 0;
    bit              e_done = 0;
    logic [15:0]     e_dcnt = '0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            mq.delete(); pend.delete();
            e_cv = 0; e_ca = '0; e_cd = '0; rem = 0; e_done = 0; e_dcnt = '0;
        end else begin
            bit can_push;
            d_t d;
            w_t w;
            can_push = (mq.size() < 4);
            e_done = 0;
            if (!e_cv && rem == 0) begin
                if (mq.size() > 0) begin
                    d = mq.pop_front();
                    if (d.l == 0) e_done = 1;
                    else begin
                        e_cv = 1; e_ca = 5'd23; e_cd = 32'd1;
                        pend.push_back('{5'd24, d.a});
                        pend.push_back('{5'd24, d.l});
                        rem = longint'(d.l);
                    end
                end
            end else if (e_cv) begin
                if (pend.size() > 0) begin
                    w = pend.pop_front(); e_ca = w.a; e_cd = w.d;
                end else e_cv = 0;
            end else if (bus.mon_valid && bus.mon_ready) begin
                rem--;
                if (rem == 0) e_done = 1;
            end
            if (bus.desc_valid && can_push) mq.push_back('{bus.desc_addr, bus.desc_length});
            if (e_done) e_dcnt++;
        end
    end

    // ---------------- compare + word monitor ----------------
    bit chk_en = 0;
    int id_cnt = 0, wpos = 0, done_seen = 0;
    longint unsigned len_sum = 0;

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("cfg_valid",  bus.cfg_valid,  e_cv);
            chk("cfg_addr",   bus.cfg_addr,   e_ca);
            chk("cfg_data",   bus.cfg_data,   e_cd);
            chk("busy",       busy,           (e_cv || rem != 0 || mq.size() != 0));
            chk("desc_ready", bus.desc_ready, (mq.size() < 4));
`ifdef AXIS_READ_SCHED_STATUS_EN
            chk("done",       done,           e_done);
            chk("done_cnt",   done_cnt,       e_dcnt);
            if (done === 1'b1) done_seen++;
`endif
            if (bus.cfg_valid === 1'b1) begin
                if (bus.cfg_addr == 5'd23) begin id_cnt++; wpos = 1; end
                else wpos++;
                if (wpos == 3) len_sum += bus.cfg_data;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic nxt(); @(negedge clk); endtask

    task automatic put(input logic [31:0] a, input logic [31:0] l);
        bus.desc_valid = 1'b1; bus.desc_addr = a; bus.desc_length = l;
    endtask

    task automatic beats(input bit v, input bit r);
        bus.mon_valid = v; bus.mon_ready = r;
    endtask

    task automatic wait_idle(input string nm, input int bound);
        for (int i = 0; i < bound; i++) begin
            nxt();
            if (busy === 1'b0) break;
        end
        chk(nm, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int id_snap, hs, done_snap;
    longint unsigned len_snap;
    logic [15:0] dcnt_snap;

    initial begin
        bus.desc_valid = 0; bus.desc_addr = '0; bus.desc_length = '0;
        beats(0, 0);
        repeat (2) nxt();
        chk_en = 1;
        chk("rst_cfg_valid", bus.cfg_valid, 1'b0);
        chk("rst_cfg_addr",  bus.cfg_addr,  5'd0);
        chk("rst_cfg_data",  bus.cfg_data,  32'd0);
        chk("rst_busy",      busy,          1'b0);
        chk("rst_ready",     bus.desc_ready, 1'b1);

        // 1: single descriptor, ready held high
        rst = 0;
        put(32'h1000_0000, 32'd8);
        beats(1, 1);
        for (int i = 1; i <= 13; i++) begin
            nxt();
            if (i == 1) bus.desc_valid = 0;
            if (i == 2) begin chk("t1_w0_a", bus.cfg_addr, 5'd23); chk("t1_w0_d", bus.cfg_data, 32'd1); chk("t1_w0_v", bus.cfg_valid, 1'b1); end
            if (i == 3) begin chk("t1_w1_a", bus.cfg_addr, 5'd24); chk("t1_w1_d", bus.cfg_data, 32'h1000_0000); end
            if (i == 4) begin chk("t1_w2_a", bus.cfg_addr, 5'd24); chk("t1_w2_d", bus.cfg_data, 32'd8); end
            if (i == 5) chk("t1_run_v", bus.cfg_valid, 1'b0);
            if (i == 12) chk("t1_busy_hi", busy, 1'b1);
            if (i == 13) chk("t1_busy_lo", busy, 1'b0);
        end

        // 2: four descriptors queued behind a stalled len=1 transfer
        beats(0, 0);
        put(32'h2000, 32'd1);
        nxt(); put(32'h2100, 32'd3);
        nxt(); put(32'h2200, 32'd5);
        nxt(); put(32'h2300, 32'd1);
        nxt(); put(32'h2400, 32'd2);
        nxt(); bus.desc_valid = 0;
        chk("t2_full_ready", bus.desc_ready, 1'b0);
        chk("t2_full_busy",  busy,           1'b1);
        id_snap = id_cnt; len_snap = len_sum;
        beats(1, 1);
        wait_idle("t2_idle", 200);
        chk("t2_ids",     id_cnt - id_snap,   4);
        chk("t2_len_sum", len_sum - len_snap, 11);

        // 3: ready toggling, len=4
        beats(0, 0);
        put(32'h3000, 32'd4);
        nxt(); bus.desc_valid = 0;
        repeat (4) nxt();
        hs = 0;
        for (int i = 0; i < 40; i++) begin
            beats(1, (i % 2) == 0);
            if (bus.mon_ready) hs++;
            nxt();
            if (busy === 1'b0) break;
        end
        chk("t3_handshakes", hs, 4);
        chk("t3_idle", busy, 1'b0);

        // 4: zero-length descriptor then len=2
        beats(1, 1);
        id_snap = id_cnt; done_snap = done_seen;
`ifdef AXIS_READ_SCHED_STATUS_EN
        dcnt_snap = done_cnt;
`else
        dcnt_snap = '0;
`endif
        put(32'h4000, 32'd0);
        nxt(); put(32'h5000, 32'd2);
        nxt(); bus.desc_valid = 0;
        wait_idle("t4_idle", 50);
        nxt();
        chk("t4_ids", id_cnt - id_snap, 1);
`ifdef AXIS_READ_SCHED_STATUS_EN
        chk("t4_done_pulses", done_seen - done_snap, 2);
        chk("t4_done_cnt",    16'(done_cnt - dcnt_snap), 16'd2);
`endif

        // 5: reset in RUN after 3 of 10 beats, two queued
        beats(0, 0);
        put(32'h6000, 32'd10);
        nxt(); put(32'h6100, 32'd7);
        nxt(); put(32'h6200, 32'd9);
        nxt(); bus.desc_valid = 0;
        nxt(); nxt();
        beats(1, 1);
        repeat (3) nxt();
        beats(0, 0);
        chk("t5_pre_busy", busy, 1'b1);
        rst = 1;
        nxt();
        chk("t5_busy",      busy,           1'b0);
        chk("t5_ready",     bus.desc_ready, 1'b1);
        chk("t5_cfg_valid", bus.cfg_valid,  1'b0);
        rst = 0;
        id_snap = id_cnt;
        repeat (10) nxt();
        chk("t5_no_words", id_cnt - id_snap, 0);

        // 6: full-range length, beat counter preloaded near the end
        put(32'h7000, 32'hFFFF_FFFF);
        nxt(); bus.desc_valid = 0;
        repeat (4) nxt();
        force dut.cnt_q = 32'hFFFF_FFFC;
        rem = 3;
        nxt();
        release dut.cnt_q;
        beats(1, 1);
        nxt();
        nxt();
        chk("t6_busy_2", busy, 1'b1);
        nxt();
        beats(0, 0);
        chk("t6_done", busy, 1'b0);
        repeat (3) nxt();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
